// File: rtl/noc_pkg.sv
// Shared router definitions: link geometry, header fields, port indices and
// the output-port state encoding.
package noc_pkg;

    localparam int FLIT_W    = 32;
    localparam int PKT_FLITS = 4;

    // Header flit destination fields
    localparam int DST_X_HI = 31;
    localparam int DST_X_LO = 28;
    localparam int DST_Y_HI = 27;
    localparam int DST_Y_LO = 24;

    // Router port indices
    localparam int XPLUS  = 0;
    localparam int XMINUS = 1;
    localparam int YPLUS  = 2;
    localparam int YMINUS = 3;
    localparam int PE     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } outport_state_e;

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter: consume decrements, ret increments, both
// together leave the count unchanged. Starts full at MAX.
module credit_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         consume,
    input  logic         ret,
    output logic [W-1:0] count,
    output logic         nonzero,
    output logic         overflow
);

    // Flags decoded from the count; overflow marks a return with no room left
    always_comb begin
        nonzero  = (count != '0);
        overflow = ret && !consume && (count == W'(MAX));
    end

    // Count register, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= W'(MAX);
        end else if (consume && !ret && (count != '0)) begin
            count <= count - W'(1);
        end else if (ret && !consume && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/outport.sv
// Router output port: registers one packet at a time from the crossbar onto
// the link, flags packet start on the diff pair and tracks downstream credits.
module outport
    import noc_pkg::*;
#(
    parameter int FLIT_W    = noc_pkg::FLIT_W,
    parameter int PKT_FLITS = noc_pkg::PKT_FLITS,
    parameter int CREDITS   = 4,
    parameter int CRD_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] xbar_data,
    input  logic              xbar_valid,
    output logic              port_ready,
    input  logic              crt_in,
    output logic [FLIT_W-1:0] output_channel,
    output logic              diff_pair_p,
    output logic              diff_pair_n,
    output logic [CRD_W-1:0]  credit_cnt,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(PKT_FLITS + 1);

    outport_state_e   state;
    outport_state_e   state_next;
    logic [CNT_W-1:0] flit_cnt;
    logic [CNT_W-1:0] flit_cnt_next;
    logic [CNT_W-1:0] flit_cnt_inc;
    logic             accept;
    logic             pass_flit;
    logic             hdr_err;
    logic             credit_nonzero;
    logic             credit_ovf;

    credit_counter #(
        .MAX (CREDITS),
        .W   (CRD_W)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .consume  (accept),
        .ret      (crt_in),
        .count    (credit_cnt),
        .nonzero  (credit_nonzero),
        .overflow (credit_ovf)
    );

    // State register: packet FSM and flit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flit_cnt <= '0;
        end else begin
            state    <= state_next;
            flit_cnt <= flit_cnt_next;
        end
    end

    // Next-state logic: header opens a packet, the last flit closes it
    always_comb begin
        state_next    = state;
        flit_cnt_next = flit_cnt;
        flit_cnt_inc  = flit_cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = SEND;
                    flit_cnt_next = CNT_W'(1);
                end
            end
            SEND: begin
                if (xbar_valid) begin
                    if (flit_cnt_inc == CNT_W'(PKT_FLITS)) begin
                        state_next    = IDLE;
                        flit_cnt_next = '0;
                    end else begin
                        flit_cnt_next = flit_cnt_inc;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                flit_cnt_next = '0;
            end
        endcase
    end

    // Output decode: ready comes from registers only; strobes qualify the link
    always_comb begin
        port_ready  = (state == IDLE) && credit_nonzero;
        accept      = (state == IDLE) && xbar_valid && port_ready;
        pass_flit   = (state == SEND) && xbar_valid;
        hdr_err     = (state == IDLE) && xbar_valid && !port_ready;
        diff_pair_n = ~diff_pair_p;
    end

    // Link register: one-cycle flit latency, zero when idle, toggle on header
    always_ff @(posedge clk) begin
        if (rst) begin
            output_channel <= '0;
            diff_pair_p    <= 1'b1;
        end else begin
            output_channel <= (accept || pass_flit) ? xbar_data : '0;
            if (accept) begin
                diff_pair_p <= ~diff_pair_p;
            end
        end
    end

    // Sticky protocol error: dropped header or credit returned while full
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (hdr_err || credit_ovf) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_outport.sv
// Directed bench for outport: reset state, single and back-to-back packets,
// credit exhaustion and return, credit overflow, gaps and mid-packet reset.
module tb_outport;

    logic        clk;
    logic        rst;
    logic [31:0] xbar_data;
    logic        xbar_valid;
    logic        port_ready;
    logic        crt_in;
    logic [31:0] output_channel;
    logic        diff_pair_p;
    logic        diff_pair_n;
    logic [2:0]  credit_cnt;
    logic        proto_err;

    int   n_tests;
    int   n_fail;
    logic exp_dp;

    outport dut (
        .clk            (clk),
        .rst            (rst),
        .xbar_data      (xbar_data),
        .xbar_valid     (xbar_valid),
        .port_ready     (port_ready),
        .crt_in         (crt_in),
        .output_channel (output_channel),
        .diff_pair_p    (diff_pair_p),
        .diff_pair_n    (diff_pair_n),
        .credit_cnt     (credit_cnt),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c);
        xbar_valid = v;
        xbar_data  = d;
        crt_in     = c;
        tick();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        xbar_valid = 1'b0;
        xbar_data  = '0;
        crt_in     = 1'b0;
        tick();
        rst    = 1'b0;
        exp_dp = 1'b1;
    endtask

    // Sends one 4-flit packet with no gaps, checking link and diff pair per flit
    task automatic send_pkt(input logic [31:0] hdr, input logic c_on_hdr);
        logic [31:0] f [4];
        f[0] = hdr;
        f[1] = 32'h00FF0000;
        f[2] = 32'h0000FF00;
        f[3] = 32'h000000FF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, f[i], (i == 0) ? c_on_hdr : 1'b0);
            if (i == 0) exp_dp = !exp_dp;
            check("link", output_channel, f[i]);
            check("dp_p", diff_pair_p, exp_dp);
            check("dp_n", diff_pair_n, !exp_dp);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_dp     = 1'b1;
        rst        = 1'b1;
        xbar_valid = 1'b0;
        xbar_data  = '0;
        crt_in     = 1'b0;

        // Reset state
        repeat (20) tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rst_link", output_channel, 32'h0);
        check("rst_dp_p", diff_pair_p, 1'b1);
        check("rst_dp_n", diff_pair_n, 1'b0);
        check("rst_credit", credit_cnt, 3'd4);
        check("rst_ready", port_ready, 1'b1);
        check("rst_err", proto_err, 1'b0);

        // Single packet
        send_pkt(32'h33000000, 1'b0);
        check("p1_credit", credit_cnt, 3'd3);
        check("p1_ready", port_ready, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        check("p1_link_idle", output_channel, 32'h0);
        check("p1_dp_hold", diff_pair_p, 1'b0);

        // One credit return restores full credit
        drive(1'b0, 32'h0, 1'b1);
        check("ret_credit", credit_cnt, 3'd4);
        check("ret_err", proto_err, 1'b0);

        // Two back-to-back packets
        send_pkt(32'h33000000, 1'b0);
        send_pkt(32'h11000000, 1'b0);
        check("b2b_credit", credit_cnt, 3'd2);
        drive(1'b0, 32'h0, 1'b0);
        check("b2b_link_idle", output_channel, 32'h0);

        // Credit exhaustion, dropped header, credit return
        do_reset();
        send_pkt(32'h10000000, 1'b0);
        check("ex_credit3", credit_cnt, 3'd3);
        send_pkt(32'h20000000, 1'b0);
        check("ex_credit2", credit_cnt, 3'd2);
        send_pkt(32'h30000000, 1'b0);
        check("ex_credit1", credit_cnt, 3'd1);
        send_pkt(32'h40000000, 1'b0);
        check("ex_credit0", credit_cnt, 3'd0);
        check("ex_ready0", port_ready, 1'b0);
        check("ex_err0", proto_err, 1'b0);
        drive(1'b1, 32'h55000000, 1'b0);
        check("drop_link", output_channel, 32'h0);
        check("drop_err", proto_err, 1'b1);
        check("drop_dp", diff_pair_p, exp_dp);
        check("drop_credit", credit_cnt, 3'd0);
        drive(1'b0, 32'h0, 1'b1);
        check("ex_ret_credit", credit_cnt, 3'd1);
        check("ex_ret_ready", port_ready, 1'b1);
        check("ex_err_sticky", proto_err, 1'b1);

        // Header with simultaneous credit return, then overflow
        do_reset();
        check("rst_err_clr", proto_err, 1'b0);
        send_pkt(32'h12000000, 1'b0);
        send_pkt(32'h21000000, 1'b0);
        check("co_credit2", credit_cnt, 3'd2);
        send_pkt(32'h22000000, 1'b1);
        check("co_same_cycle", credit_cnt, 3'd2);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("co_full", credit_cnt, 3'd4);
        check("co_err_pre", proto_err, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        check("ovf_credit", credit_cnt, 3'd4);
        check("ovf_err", proto_err, 1'b1);

        // Gap mid-packet, then reset mid-packet
        do_reset();
        drive(1'b1, 32'h33000000, 1'b0);
        exp_dp = !exp_dp;
        check("gap_hdr", output_channel, 32'h33000000);
        check("gap_ready_send", port_ready, 1'b0);
        drive(1'b1, 32'hA5A5A5A5, 1'b0);
        check("gap_f1", output_channel, 32'hA5A5A5A5);
        drive(1'b0, 32'hDEADBEEF, 1'b0);
        check("gap_link0", output_channel, 32'h0);
        drive(1'b0, 32'hDEADBEEF, 1'b0);
        check("gap_link1", output_channel, 32'h0);
        check("gap_ready", port_ready, 1'b0);
        drive(1'b1, 32'h5A5A5A5A, 1'b0);
        check("gap_f2", output_channel, 32'h5A5A5A5A);
        check("gap_cnt_held", port_ready, 1'b0);
        check("gap_dp", diff_pair_p, exp_dp);
        rst        = 1'b1;
        xbar_valid = 1'b1;
        xbar_data  = 32'hCAFEF00D;
        tick();
        rst    = 1'b0;
        exp_dp = 1'b1;
        xbar_valid = 1'b0;
        check("mrst_link", output_channel, 32'h0);
        check("mrst_dp_p", diff_pair_p, 1'b1);
        check("mrst_dp_n", diff_pair_n, 1'b0);
        check("mrst_credit", credit_cnt, 3'd4);
        check("mrst_ready", port_ready, 1'b1);
        check("mrst_err", proto_err, 1'b0);
        send_pkt(32'h44000000, 1'b0);
        check("post_credit", credit_cnt, 3'd3);
        check("post_ready", port_ready, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        check("post_link_idle", output_channel, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/outport.md
Name: outport

Overview:
- Router output-port stage, directly downstream of the crossbar that carries flits granted out of an `inport`.
- Accepts one 4-flit packet at a time from the crossbar and registers it onto the inter-router link.
- Signals packet start to the neighbour's `inport` by toggling the diff_pair_p/diff_pair_n pair.
- Tracks downstream buffer space with a credit counter: one credit is consumed per packet sent, and one is returned per crt_out pulse from the neighbour.

Parameters:
- FLIT_W, 32, flit/link width in bits.
- PKT_FLITS, 4, flits per packet, header included.
- CREDITS, 4, downstream inport buffer depth in packets; initial credit count.
- CRD_W, 3, credit counter width; must hold CREDITS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- xbar_data  in  FLIT_W  flit from crossbar.
- xbar_valid  in  1  qualifies xbar_data this cycle.
- port_ready  out  1  to switch arbiter: a header may be presented this cycle.
- crt_in  in  1  one-cycle credit-return pulse from the downstream inport's crt_out.
- output_channel  out  FLIT_W  registered link data.
- diff_pair_p  out  1  packet-start toggle, true line.
- diff_pair_n  out  1  packet-start toggle, complement line; always equals ~diff_pair_p.
- credit_cnt  out  CRD_W  current credits, for debug.
- proto_err  out  1  sticky: header presented while not ready, or credit overflow.

Behaviour:
Reset:
- Reset is synchronous and active-high: rst sampled high at posedge clk.
- Reset values: state=IDLE, flit_cnt=0, credit=CREDITS, output_channel=0, diff_pair_p=1, diff_pair_n=0, proto_err=0.
- A reset mid-packet abandons the partial packet. The link returns to 0 the next cycle; no further toggle is issued.

Ready:
- port_ready = (state==IDLE) && (credit!=0). Decoded from registers only; no combinational path from inputs.

States:
- IDLE
  - xbar_valid && port_ready: accept header. Next cycle output_channel=xbar_data and both diff_pair lines invert. Credit decrements, flit_cnt=1, go to SEND.
  - xbar_valid && !port_ready: flit ignored, proto_err set, output_channel=0.
  - !xbar_valid: output_channel=0.
- SEND
  - xbar_valid: flit registered onto output_channel next cycle, flit_cnt++.
  - The flit that makes flit_cnt==PKT_FLITS returns the state to IDLE and clears flit_cnt.
  - !xbar_valid (gap): output_channel=0, counter holds, state holds.
  - The diff pair never toggles in SEND.

Timing:
- Latency is 1 cycle, xbar to link, for every flit.
- Back-to-back packets: flits at cycles N..N+3; state is IDLE at N+4, so a header at N+4 is accepted with no bubble, provided credit>0.

Credits:
- Header accept and crt_in in the same cycle: count unchanged.
- crt_in alone with credit==CREDITS: count saturates and proto_err is set.
- Credit never underflows, because a header is only accepted when credit!=0.

proto_err:
- Cleared only by rst.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W and PKT_FLITS constants;
  - header field positions: destination X in bits [31:28], Y in bits [27:24];
  - port index constants XPLUS, XMINUS, YPLUS, YMINUS, PE;
  - the outport state encoding (IDLE, SEND).
- One natural sub-module: credit_counter. Behaviour: saturating up/down counter with consume/return inputs, nonzero flag and overflow flag; reused by the PE injection port.

Test Plan:
- Reset for 20 cycles, then idle 4 cycles -> output_channel=0, diff_pair_p=1, diff_pair_n=0, credit_cnt=4, port_ready=1, proto_err=0.
- Single packet 33000000, 00FF0000, 0000FF00, 000000FF at cycles N..N+3 -> link carries the same flits at N+1..N+4; diff_pair_p=0 and diff_pair_n=1 from N+1; credit_cnt=3; link=0 at N+5.
- Two back-to-back packets (header 33000000, then 11000000 at N+4) -> 8 contiguous link flits, two diff-pair toggles 4 cycles apart, credit_cnt=2.
- Four packets with no crt_in -> credit_cnt=0 and port_ready=0; a fifth header is dropped and proto_err=1. One crt_in pulse -> credit_cnt=1 and port_ready=1.
- Header accept coinciding with crt_in (credit 2) -> credit_cnt stays 2. A crt_in pulse at credit_cnt=4 -> credit_cnt stays 4 and proto_err=1.
- xbar_valid gap of 2 cycles after the second flit, then rst asserted mid-packet -> link=0 during the gap with flit_cnt held; after rst, all outputs return to their reset values and the next header is accepted normally.
